vram_write_ctrl: RTL
====================

Name: vram_write_ctrl

Overview:
Write-port sequencer for the 256x256x1 frame VRAM behind the 800x600 VGA controller. It accepts the binarized pixel stream from the adaptive-thresholding pipeline and converts it into raster-ordered write_x/write_y/write_value writes. It also runs a full-screen clear sweep and can defer a frame start to vertical blanking to avoid tearing. Its outputs drive the VGA controller's write_x, write_y and write_value inputs directly.

Parameters:
WIDTH, 256, pixels per line accepted from the stream (1..256)
HEIGHT, 256, lines per frame (1..256)
CLEAR_VALUE, 0, 1-bit value written by the clear sweep
SYNC_TO_VBLANK, 1, 1 = hold a frame start until iVBlank is high; 0 = start immediately

Ports:
iCLK  in  1  pixel clock (40 MHz), shared with the VGA controller
iRST  in  1  synchronous, active-high reset
iClear  in  1  one-cycle request: clear the whole VRAM
iFrame_start  in  1  one-cycle request: begin accepting one frame
iAbort  in  1  abandon the current operation
iVBlank  in  1  high during VGA vertical blanking
iPix_valid  in  1  stream pixel valid
iPix_value  in  1  binarized pixel value
oPix_ready  out  1  stream ready
write_x  out  8  VRAM write column
write_y  out  8  VRAM write row
write_value  out  1  VRAM write data
oWren  out  1  write strobe; high for exactly the cycles that carry a new write
oBusy  out  1  high whenever the state is not IDLE
oDone  out  1  one-cycle pulse when a clear or a frame completes

Behaviour:
- Reset (iRST sampled high at a rising edge of iCLK): state IDLE; all outputs 0; x/y counters 0. Reset mid-operation abandons the operation with no oDone pulse.
- All outputs are registered.
- When oWren=0, write_x/write_y/write_value hold their last values. The VRAM wren is tied high, so holding rewrites an identical value and is harmless.
- States: IDLE, CLEAR, WAIT_VB, STREAM.
- IDLE:
  - iClear -> CLEAR.
  - iFrame_start -> WAIT_VB if SYNC_TO_VBLANK=1, otherwise -> STREAM.
  - If both are high in the same cycle, iClear wins and iFrame_start is dropped.
  - Requests arriving in any state other than IDLE are ignored, not queued.
- CLEAR:
  - Issues one write per cycle at (x,y) with value CLEAR_VALUE.
  - x runs fastest, 0..255, then y increments, 0..255. The sweep always covers the full 256x256 array regardless of WIDTH/HEIGHT: 65536 writes.
  - First write appears on the outputs 1 cycle after the request.
  - The cycle after the write at (255,255) is issued: state -> IDLE, oDone=1 for one cycle.
  - oPix_ready=0 throughout.
- WAIT_VB: oPix_ready=0; when iVBlank=1 -> STREAM next cycle. Counters are 0 on entry.
- STREAM:
  - oPix_ready=1.
  - Handshake: a pixel is accepted on a cycle with iPix_valid && oPix_ready.
  - An accepted pixel appears on the outputs the next cycle: write_x=x, write_y=y, write_value=iPix_value, oWren=1.
  - Cycles with iPix_valid=0 produce oWren=0; counters do not advance.
  - Counter advance: x increments; at x==WIDTH-1, x wraps to 0 and y increments. Counter arithmetic is 8-bit with an explicit compare, so WIDTH=256 wraps at 255.
  - After accepting the pixel at (WIDTH-1, HEIGHT-1): oPix_ready drops the next cycle, state -> IDLE, oDone=1 coincident with the last oWren.
- iAbort in any non-IDLE state:
  - Next cycle: IDLE, oWren=0, oPix_ready=0, no oDone.
  - A pixel accepted in the same cycle as iAbort is still written.
- iAbort takes priority over every transition except reset.
- oBusy is registered and equals (state != IDLE).

Decomposition:
- Shared package: state encoding (IDLE=2'd0, CLEAR=2'd1, WAIT_VB=2'd2, STREAM=2'd3); the VRAM geometry constants VRAM_W=256, VRAM_H=256, and address width 8. The VGA side uses the same constants.
- One natural sub-module, raster_addr_gen: x/y counter with an advance enable, parameterised wrap limits, and a last-pixel flag.
- CLEAR instantiates raster_addr_gen with limits 256x256; STREAM uses limits WIDTH x HEIGHT. The two can share one instance with muxed limits.

Test Plan:
- Reset then iClear pulse -> oWren=1 for exactly 65536 consecutive cycles, starting at (0,0); the last write is (255,255) with value 0; oDone pulses once; oBusy falls the same cycle oDone rises.
- WIDTH=4, HEIGHT=2, SYNC_TO_VBLANK=0, valid held high with values 1,0,1,1,0,0,1,0 -> writes (0,0)=1 (1,0)=0 (2,0)=1 (3,0)=1 (0,1)=0 (1,1)=0 (2,1)=1 (3,1)=0; oDone with the 8th write.
- SYNC_TO_VBLANK=1, iFrame_start while iVBlank=0 for 50 cycles -> oPix_ready=0 and oWren=0 throughout; iVBlank rises -> oPix_ready=1 on the next cycle.
- iPix_valid toggling 1,0,0,1 in STREAM -> exactly 2 writes at (0,0) and (1,0); write_x/write_y hold during the gaps.
- iClear and iFrame_start pulsed together -> CLEAR sweep runs; no pixels accepted; iFrame_start issued mid-sweep is ignored.
- iAbort after 10 pixels (WIDTH=256) -> IDLE next cycle, no oDone. A following iFrame_start restarts at (0,0). iRST at clear write 1000 -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/vram_write_ctrl_pkg.sv
// Shared definitions for the frame-VRAM write sequencer: controller states,
// VRAM geometry and the coordinate type also used by the VGA read side.
package vram_write_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int VRAM_W = 256;
    localparam int VRAM_H = 256;

    typedef logic [ADDR_W-1:0] coord_t;

    localparam coord_t VRAM_X_MAX = coord_t'(VRAM_W - 1);
    localparam coord_t VRAM_Y_MAX = coord_t'(VRAM_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_WAIT_VB = 2'd2,
        ST_STREAM  = 2'd3
    } state_e;

    function automatic logic at_last(input coord_t x, input coord_t y,
                                     input coord_t x_max, input coord_t y_max);
        return (x == x_max) && (y == y_max);
    endfunction

endpackage

// File: rtl/vram_write_ctrl_if.sv
// Request, pixel-stream and VRAM write-port bundle between the thresholding
// pipeline, the write sequencer (slave) and the VGA controller write inputs.
interface vram_write_ctrl_if;
    import vram_write_ctrl_pkg::*;

    logic   iClear;
    logic   iFrame_start;
    logic   iAbort;
    logic   iVBlank;
    logic   iPix_valid;
    logic   iPix_value;
    logic   oPix_ready;
    coord_t write_x;
    coord_t write_y;
    logic   write_value;
    logic   oWren;
    logic   oBusy;
    logic   oDone;

    modport slave (
        input  iClear, iFrame_start, iAbort, iVBlank, iPix_valid, iPix_value,
        output oPix_ready, write_x, write_y, write_value, oWren, oBusy, oDone
    );

    modport master (
        output iClear, iFrame_start, iAbort, iVBlank, iPix_valid, iPix_value,
        input  oPix_ready, write_x, write_y, write_value, oWren, oBusy, oDone
    );

endinterface

// File: rtl/vram_write_ctrl_raster_addr_gen.sv
// Raster x/y counter: x runs fastest and wraps at x_max, y wraps at y_max.
// last flags that the current position is the final one of the raster.
module raster_addr_gen
    import vram_write_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   adv,
    input  coord_t x_max,
    input  coord_t y_max,
    output coord_t x,
    output coord_t y,
    output logic   last
);

    coord_t x_q, x_d;
    coord_t y_q, y_d;

    // Next position; clr outranks adv so an abort always lands at the origin.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (x_q == x_max) begin
                x_d = '0;
                if (y_q == y_max) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + 8'd1;
                end
            end else begin
                x_d = x_q + 8'd1;
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = at_last(x_q, y_q, x_max, y_max);

endmodule

// File: rtl/vram_write_ctrl.sv
// Write-port sequencer for the 256x256x1 frame VRAM: full-screen clear sweep
// and raster-ordered writes of a binarized pixel stream, optionally vblank-synced.
module vram_write_ctrl
    import vram_write_ctrl_pkg::*;
#(
    parameter int   WIDTH          = 256,
    parameter int   HEIGHT         = 256,
    parameter logic CLEAR_VALUE    = 1'b0,
    parameter bit   SYNC_TO_VBLANK = 1'b1
) (
    input  logic             iCLK,
    input  logic             iRST,
    vram_write_ctrl_if.slave bus
);

    localparam coord_t STREAM_X_MAX = coord_t'(WIDTH - 1);
    localparam coord_t STREAM_Y_MAX = coord_t'(HEIGHT - 1);

    state_e state_q, state_d;
    coord_t wx_q, wx_d;
    coord_t wy_q, wy_d;
    logic   wv_q, wv_d;
    logic   wren_q, wren_d;
    logic   done_q, done_d;
    logic   busy_q, busy_d;
    logic   ready_q, ready_d;
    logic   clr_last_q, clr_last_d;

    logic   clear_req_s;
    logic   frame_req_s;
    logic   accept_s;
    logic   adv_s;
    logic   clr_s;
    logic   cnt_last_s;
    coord_t cnt_x_s;
    coord_t cnt_y_s;
    coord_t x_max_s;
    coord_t y_max_s;

    // iClear beats iFrame_start; an abort suppresses both.
    assign clear_req_s = bus.iClear && !bus.iAbort;
    assign frame_req_s = bus.iFrame_start && !bus.iClear && !bus.iAbort;
    assign accept_s    = bus.iPix_valid && ready_q;

    // The clear sweep always covers the whole array; streaming uses the frame size.
    always_comb begin
        if (state_q == ST_STREAM) begin
            x_max_s = STREAM_X_MAX;
            y_max_s = STREAM_Y_MAX;
        end else begin
            x_max_s = VRAM_X_MAX;
            y_max_s = VRAM_Y_MAX;
        end
    end

    raster_addr_gen u_addr (
        .clk   (iCLK),
        .rst   (iRST),
        .clr   (clr_s),
        .adv   (adv_s),
        .x_max (x_max_s),
        .y_max (y_max_s),
        .x     (cnt_x_s),
        .y     (cnt_y_s),
        .last  (cnt_last_s)
    );

    // State register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req_s) begin
                    state_d = ST_CLEAR;
                end else if (frame_req_s) begin
                    state_d = SYNC_TO_VBLANK ? ST_WAIT_VB : ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (bus.iAbort || clr_last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_WAIT_VB: begin
                if (bus.iAbort) begin
                    state_d = ST_IDLE;
                end else if (bus.iVBlank) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_WAIT_VB;
                end
            end
            ST_STREAM: begin
                if (bus.iAbort || (accept_s && cnt_last_s)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and counter-control logic; write bus holds its value between writes.
    always_comb begin
        wx_d       = wx_q;
        wy_d       = wy_q;
        wv_d       = wv_q;
        wren_d     = 1'b0;
        done_d     = 1'b0;
        clr_last_d = 1'b0;
        adv_s      = 1'b0;
        clr_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The first clear write leaves with the request itself.
                if (clear_req_s) begin
                    wx_d   = cnt_x_s;
                    wy_d   = cnt_y_s;
                    wv_d   = CLEAR_VALUE;
                    wren_d = 1'b1;
                    adv_s  = 1'b1;
                end else begin
                    clr_s  = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (bus.iAbort) begin
                    clr_s  = 1'b1;
                end else if (clr_last_q) begin
                    done_d = 1'b1;
                end else begin
                    wx_d       = cnt_x_s;
                    wy_d       = cnt_y_s;
                    wv_d       = CLEAR_VALUE;
                    wren_d     = 1'b1;
                    adv_s      = 1'b1;
                    clr_last_d = cnt_last_s;
                end
            end
            ST_WAIT_VB: begin
                if (bus.iAbort) begin
                    clr_s = 1'b1;
                end else begin
                    clr_s = 1'b0;
                end
            end
            ST_STREAM: begin
                if (accept_s) begin
                    wx_d   = cnt_x_s;
                    wy_d   = cnt_y_s;
                    wv_d   = bus.iPix_value;
                    wren_d = 1'b1;
                    adv_s  = 1'b1;
                    done_d = cnt_last_s && !bus.iAbort;
                end else begin
                    adv_s  = 1'b0;
                end
                if (bus.iAbort) begin
                    clr_s = 1'b1;
                end else begin
                    clr_s = 1'b0;
                end
            end
            default: begin
                clr_s = 1'b1;
            end
        endcase
        ready_d = (state_d == ST_STREAM);
        busy_d  = (state_d != ST_IDLE);
    end

    // Output registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wx_q       <= '0;
            wy_q       <= '0;
            wv_q       <= 1'b0;
            wren_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            clr_last_q <= 1'b0;
        end else begin
            wx_q       <= wx_d;
            wy_q       <= wy_d;
            wv_q       <= wv_d;
            wren_q     <= wren_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            clr_last_q <= clr_last_d;
        end
    end

    assign bus.write_x     = wx_q;
    assign bus.write_y     = wy_q;
    assign bus.write_value = wv_q;
    assign bus.oWren       = wren_q;
    assign bus.oDone       = done_q;
    assign bus.oBusy       = busy_q;
    assign bus.oPix_ready  = ready_q;

endmodule
